// File: rtl/rtc_escritura_bus_if.sv
// ---------------------------------------------------------------------------
// rtc_escritura_bus_if
// Groups the controller handshake and the RTC multiplexed-bus signals of the
// write-cycle generator.
//   Controller side : Inicio_E (start), addr_in, dato_in (write operands),
//                     Fin_E (done pulse), busy (transaction in progress)
//   RTC bus side    : CS_n, WR_n, AD, bus_out, bus_oe
// Modports:
//   master : the programming controller / environment driving the requests
//   slave  : the bus-cycle generator serving the requests and driving the bus
// ---------------------------------------------------------------------------
interface rtc_escritura_bus_if;
  logic       Inicio_E;
  logic [7:0] addr_in;
  logic [7:0] dato_in;
  logic       Fin_E;
  logic       busy;
  logic       CS_n;
  logic       WR_n;
  logic       AD;
  logic [7:0] bus_out;
  logic       bus_oe;

  modport master (
    output Inicio_E, addr_in, dato_in,
    input  Fin_E, busy, CS_n, WR_n, AD, bus_out, bus_oe
  );

  modport slave (
    input  Inicio_E, addr_in, dato_in,
    output Fin_E, busy, CS_n, WR_n, AD, bus_out, bus_oe
  );
endinterface

// File: rtl/rtc_escritura_bus.sv
// ---------------------------------------------------------------------------
// rtc_escritura_bus
// Generates one complete RTC register write (address phase, gap, data phase)
// for every start request accepted in IDLE, then returns a one-cycle Fin_E.
// Ports:
//   clk    : single rising-edge clock
//   reset  : synchronous, active-low reset
//   bus    : rtc_escritura_bus_if.slave (Inicio_E/addr_in/dato_in in,
//            Fin_E/busy/CS_n/WR_n/AD/bus_out/bus_oe out)
// Parameters T_SU, T_PW, T_H, T_GAP give the length in cycles (1..255) of the
// setup, strobe, hold and inter-phase gap states.
// ---------------------------------------------------------------------------
module rtc_escritura_bus #(
  parameter logic [7:0] T_SU  = 8'd2,
  parameter logic [7:0] T_PW  = 8'd8,
  parameter logic [7:0] T_H   = 8'd2,
  parameter logic [7:0] T_GAP = 8'd4
) (
  input  logic                      clk,
  input  logic                      reset,
  rtc_escritura_bus_if.slave        bus
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    A_SU = 4'd1,
    A_PW = 4'd2,
    A_H  = 4'd3,
    GAP  = 4'd4,
    D_SU = 4'd5,
    D_PW = 4'd6,
    D_H  = 4'd7,
    DONE = 4'd8
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] dato_q, dato_d;

  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       ad_q, ad_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       bus_oe_q, bus_oe_d;
  logic       fin_q, fin_d;
  logic       busy_q, busy_d;

  // State, counter, captured operands and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 8'd0;
      dato_q    <= 8'd0;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_q      <= 1'b1;
      bus_out_q <= 8'd0;
      bus_oe_q  <= 1'b0;
      fin_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      dato_q    <= dato_d;
      cs_n_q    <= cs_n_d;
      wr_n_q    <= wr_n_d;
      ad_q      <= ad_d;
      bus_out_q <= bus_out_d;
      bus_oe_q  <= bus_oe_d;
      fin_q     <= fin_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and cycle counter: each timed state is entered with (len-1)
  // in the counter and left on the cycle the counter is found at zero, so a
  // length of 1 leaves after one cycle without ever decrementing past zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dato_d  = dato_q;
    case (state_q)
      IDLE: begin
        if (bus.Inicio_E) begin
          state_d = A_SU;
          cnt_d   = T_SU - 8'd1;
          addr_d  = bus.addr_in;
          dato_d  = bus.dato_in;
        end else begin
          state_d = IDLE;
        end
      end
      A_SU: begin
        if (cnt_q == 8'd0) begin
          state_d = A_PW;
          cnt_d   = T_PW - 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      A_PW: begin
        if (cnt_q == 8'd0) begin
          state_d = A_H;
          cnt_d   = T_H - 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      A_H: begin
        if (cnt_q == 8'd0) begin
          state_d = GAP;
          cnt_d   = T_GAP - 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = D_SU;
          cnt_d   = T_SU - 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      D_SU: begin
        if (cnt_q == 8'd0) begin
          state_d = D_PW;
          cnt_d   = T_PW - 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      D_PW: begin
        if (cnt_q == 8'd0) begin
          state_d = D_H;
          cnt_d   = T_H - 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      D_H: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output decode from the state being entered, so the registered outputs
  // describe that state during the cycle that follows the edge. The operand
  // values come from the _d side so the address is already valid in the
  // first A_SU cycle.
  always_comb begin
    cs_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    ad_d      = 1'b1;
    bus_out_d = 8'd0;
    bus_oe_d  = 1'b0;
    fin_d     = 1'b0;
    busy_d    = 1'b1;
    case (state_d)
      IDLE: begin
        busy_d = 1'b0;
      end
      A_SU, A_H: begin
        cs_n_d    = 1'b0;
        ad_d      = 1'b0;
        bus_oe_d  = 1'b1;
        bus_out_d = addr_d;
      end
      A_PW: begin
        cs_n_d    = 1'b0;
        wr_n_d    = 1'b0;
        ad_d      = 1'b0;
        bus_oe_d  = 1'b1;
        bus_out_d = addr_d;
      end
      GAP: begin
        cs_n_d = 1'b1;
      end
      D_SU, D_H: begin
        cs_n_d    = 1'b0;
        bus_oe_d  = 1'b1;
        bus_out_d = dato_d;
      end
      D_PW: begin
        cs_n_d    = 1'b0;
        wr_n_d    = 1'b0;
        bus_oe_d  = 1'b1;
        bus_out_d = dato_d;
      end
      DONE: begin
        fin_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.CS_n    = cs_n_q;
  assign bus.WR_n    = wr_n_q;
  assign bus.AD      = ad_q;
  assign bus.bus_out = bus_out_q;
  assign bus.bus_oe  = bus_oe_q;
  assign bus.Fin_E   = fin_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_rtc_escritura_bus.sv
// ---------------------------------------------------------------------------
// tb_rtc_escritura_bus
// Directed bench for rtc_escritura_bus: one instance with default timing and
// one with every timing parameter at 1. Inputs are driven and outputs are
// observed on the falling edge; the value seen at the falling edge before
// rising edge k is "cycle k", rising edge 0 being the one that samples the
// start request.
// ---------------------------------------------------------------------------
module tb_rtc_escritura_bus;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   n_checks = 0;
  int   n_errors = 0;

  rtc_escritura_bus_if ifa ();
  rtc_escritura_bus_if ifb ();

  rtc_escritura_bus dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  rtc_escritura_bus #(
    .T_SU  (8'd1),
    .T_PW  (8'd1),
    .T_H   (8'd1),
    .T_GAP (8'd1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  // {CS_n, WR_n, AD, bus_oe, Fin_E, busy, bus_out}
  wire [13:0] obs_a = {ifa.CS_n, ifa.WR_n, ifa.AD, ifa.bus_oe, ifa.Fin_E, ifa.busy, ifa.bus_out};
  wire [13:0] obs_b = {ifb.CS_n, ifb.WR_n, ifb.AD, ifb.bus_oe, ifb.Fin_E, ifb.busy, ifb.bus_out};

  localparam logic [13:0] IDLE_V = 14'h3800;

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected output vector in cycle k after a start accepted at cycle 0.
  function automatic logic [13:0] exp_vec(input int k, input int su, input int pw,
                                          input int h, input int gap,
                                          input logic [7:0] a, input logic [7:0] d);
    int n;
    int ph;
    int j;
    logic cs, wr, ad, oe, fin, bsy;
    logic [7:0] bo;
    n  = 2 * (su + pw + h) + gap + 1;
    ph = su + pw + h;
    cs = 1'b1; wr = 1'b1; ad = 1'b1; oe = 1'b0; fin = 1'b0; bsy = 1'b0; bo = 8'h00;
    if (k >= 1 && k <= n) bsy = 1'b1;
    if (k == n) fin = 1'b1;
    if (k >= 1 && k <= ph) begin
      cs = 1'b0; ad = 1'b0; oe = 1'b1; bo = a;
      if (k > su && k <= su + pw) wr = 1'b0;
    end else if (k > ph + gap && k <= 2 * ph + gap) begin
      j  = k - ph - gap;
      cs = 1'b0; oe = 1'b1; bo = d;
      if (j > su && j <= su + pw) wr = 1'b0;
    end
    return {cs, wr, ad, oe, fin, bsy, bo};
  endfunction

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.Inicio_E = 1'b0; ifa.addr_in = 8'h00; ifa.dato_in = 8'h00;
    ifb.Inicio_E = 1'b0; ifb.addr_in = 8'h00; ifb.dato_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_a", obs_a, IDLE_V);
    chk("reset_b", obs_b, IDLE_V);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    chk("idle_a", obs_a, IDLE_V);

    // Single write, default timing
    ifa.addr_in = 8'h21; ifa.dato_in = 8'h59; ifa.Inicio_E = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk($sformatf("single c%0d", k), obs_a, exp_vec(k, 2, 8, 2, 4, 8'h21, 8'h59));
      if (k == 12) chk("single cs_low_c12", {13'd0, ifa.CS_n}, 14'd0);
      if (k == 13) chk("single cs_high_c13", {13'd0, ifa.CS_n}, 14'd1);
      if (k == 3)  chk("single wr_low_c3", {13'd0, ifa.WR_n}, 14'd0);
      if (k == 29) chk("single fin_c29", {13'd0, ifa.Fin_E}, 14'd1);
      ifa.Inicio_E = 1'b0;
    end

    // Operands change after capture; extra requests while busy
    ifa.addr_in = 8'h21; ifa.dato_in = 8'h59; ifa.Inicio_E = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      chk($sformatf("busyreq c%0d", k), obs_a, exp_vec(k, 2, 8, 2, 4, 8'h21, 8'h59));
      if (k == 30) chk("busyreq busy_fall_c30", {13'd0, ifa.busy}, 14'd0);
      if (k == 2) begin
        ifa.addr_in = 8'hFF; ifa.dato_in = 8'hFF;
      end
      ifa.Inicio_E = (k == 5 || k == 29) ? 1'b1 : 1'b0;
    end

    // Back-to-back with Inicio_E held high
    ifa.addr_in = 8'h21; ifa.dato_in = 8'h59; ifa.Inicio_E = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk($sformatf("b2b c%0d", k), obs_a,
          (k <= 30) ? exp_vec(k, 2, 8, 2, 4, 8'h21, 8'h59)
                    : exp_vec(k - 30, 2, 8, 2, 4, 8'h21, 8'h59));
      if (k == 31) chk("b2b cs_fall_c31", {13'd0, ifa.CS_n}, 14'd0);
      if (k == 59) chk("b2b fin_c59", {13'd0, ifa.Fin_E}, 14'd1);
      if (k == 59) ifa.Inicio_E = 1'b0;
    end

    // Reset during A_PW
    ifa.addr_in = 8'h21; ifa.dato_in = 8'h59; ifa.Inicio_E = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk($sformatf("midrst c%0d", k), obs_a,
          (k <= 5) ? exp_vec(k, 2, 8, 2, 4, 8'h21, 8'h59) : IDLE_V);
      ifa.Inicio_E = 1'b0;
      rst_a = (k == 5) ? 1'b0 : 1'b1;
    end

    // Reset and start together: reset wins, nothing starts
    rst_a = 1'b0; ifa.Inicio_E = 1'b1; ifa.addr_in = 8'h77; ifa.dato_in = 8'h88;
    @(negedge clk);
    chk("rst_start", obs_a, IDLE_V);
    rst_a = 1'b1; ifa.Inicio_E = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("rst_start idle c%0d", k), obs_a, IDLE_V);
    end

    // Fresh write after reset completes normally
    ifa.addr_in = 8'h3C; ifa.dato_in = 8'hA5; ifa.Inicio_E = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk($sformatf("postrst c%0d", k), obs_a, exp_vec(k, 2, 8, 2, 4, 8'h3C, 8'hA5));
      ifa.Inicio_E = 1'b0;
    end

    // All timing parameters at 1
    ifb.addr_in = 8'h0F; ifb.dato_in = 8'hF0; ifb.Inicio_E = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("min c%0d", k), obs_b, exp_vec(k, 1, 1, 1, 1, 8'h0F, 8'hF0));
      if (k == 8) chk("min fin_c8", {13'd0, ifb.Fin_E}, 14'd1);
      ifb.Inicio_E = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
